// File: rtl/neuron_alu2_sequencer_if.sv
// Stream and ALU2 bus between the neuron sequencer (master) and its environment (slave).
// Carries the input/weight handshake and the shared ALU2 operand/result wires.
interface neuron_alu2_sequencer_if #(
    parameter int nBits = 32
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [nBits-1:0] in_x;
    logic signed [nBits-1:0] in_w;
    logic [2:0]              alu_ctrl;
    logic signed [nBits-1:0] alu_a;
    logic signed [nBits-1:0] alu_c;
    logic signed [nBits-1:0] alu_result;

    modport master (
        input  in_valid, in_x, in_w, alu_result,
        output in_ready, alu_ctrl, alu_a, alu_c
    );

    modport slave (
        output in_valid, in_x, in_w, alu_result,
        input  in_ready, alu_ctrl, alu_a, alu_c
    );
endinterface

// File: rtl/neuron_alu2_sequencer.sv
// Drives a shared ALU2 through mul/add for NIN pairs, then a signed threshold compare.
// Optional macro NEURON_SEQ_BIAS_EN adds a bias port that seeds the accumulator.
module neuron_alu2_sequencer #(
    parameter int nBits = 32,
    parameter int NIN   = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic signed [nBits-1:0] threshold,
`ifdef NEURON_SEQ_BIAS_EN
    input  logic signed [nBits-1:0] bias,
`endif
    neuron_alu2_sequencer_if.master bus,
    output logic                    busy,
    output logic                    done,
    output logic signed [nBits-1:0] out_acc,
    output logic                    out_fire
);

    localparam int             CW       = $clog2(NIN + 1);
    localparam logic [CW-1:0]  LAST_IDX = CW'(NIN - 1);

    localparam logic [2:0] CTRL_ADD  = 3'b000;
    localparam logic [2:0] CTRL_MUL  = 3'b001;
    localparam logic [2:0] CTRL_GE   = 3'b010;
    localparam logic [2:0] CTRL_PASS = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_ACC,
        S_THRESH,
        S_DONE
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic signed [nBits-1:0] r_acc;
    logic signed [nBits-1:0] r_product;
    logic signed [nBits-1:0] r_thresh;
    logic signed [nBits-1:0] r_out_acc;
    logic                    r_out_fire;
    logic [CW-1:0]           r_count;
    logic                    w_last;
    logic signed [nBits-1:0] w_acc_init;

    // Comparing against NIN-1 avoids a wider count+1 term.
    assign w_last = (r_count == LAST_IDX);

`ifdef NEURON_SEQ_BIAS_EN
    assign w_acc_init = bias;
`else
    assign w_acc_init = '0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        busy         = 1'b1;
        done         = 1'b0;
        bus.in_ready = 1'b0;
        bus.alu_ctrl = CTRL_PASS;
        bus.alu_a    = '0;
        bus.alu_c    = '0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) w_next = S_MUL;
            end
            S_MUL: begin
                bus.in_ready = 1'b1;
                bus.alu_ctrl = CTRL_MUL;
                bus.alu_a    = bus.in_x;
                bus.alu_c    = bus.in_w;
                if (bus.in_valid) w_next = S_ACC;
            end
            S_ACC: begin
                bus.alu_ctrl = CTRL_ADD;
                bus.alu_a    = r_acc;
                bus.alu_c    = r_product;
                w_next       = w_last ? S_THRESH : S_MUL;
            end
            S_THRESH: begin
                bus.alu_ctrl = CTRL_GE;
                bus.alu_a    = r_acc;
                bus.alu_c    = r_thresh;
                w_next       = S_DONE;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                busy   = 1'b0;
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc      <= '0;
            r_product  <= '0;
            r_thresh   <= '0;
            r_count    <= '0;
            r_out_acc  <= '0;
            r_out_fire <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_thresh <= threshold;
                        r_acc    <= w_acc_init;
                        r_count  <= '0;
                    end
                end
                S_MUL: begin
                    if (bus.in_valid) r_product <= bus.alu_result;
                end
                S_ACC: begin
                    r_acc   <= bus.alu_result;
                    r_count <= r_count + 1'b1;
                end
                S_THRESH: begin
                    r_out_fire <= bus.alu_result[0];
                    r_out_acc  <= r_acc;
                end
                default: ;
            endcase
        end
    end

    assign out_acc  = r_out_acc;
    assign out_fire = r_out_fire;

endmodule

// File: tb/tb_neuron_alu2_sequencer.sv
// Directed bench for neuron_alu2_sequencer with a behavioural ALU2 on the slave side.
// Define NEURON_SEQ_BIAS_EN for both DUT and bench to exercise the bias build.
module tb_neuron_alu2_sequencer;

    localparam int NB  = 32;
    localparam int NIN = 4;

`ifdef NEURON_SEQ_BIAS_EN
    localparam logic signed [NB-1:0] BIAS = -32'sd5;
`else
    localparam logic signed [NB-1:0] BIAS = 32'sd0;
`endif

    localparam int M_MUL  = 1;
    localparam int M_ACC  = 2;
    localparam int M_THR  = 3;
    localparam int M_DONE = 4;

    typedef logic signed [NB-1:0] vec_t [NIN];

    logic                 clk       = 1'b0;
    logic                 reset_n   = 1'b0;
    logic                 start     = 1'b0;
    logic signed [NB-1:0] threshold = '0;
`ifdef NEURON_SEQ_BIAS_EN
    logic signed [NB-1:0] bias      = BIAS;
`endif
    logic                 busy;
    logic                 done;
    logic signed [NB-1:0] out_acc;
    logic                 out_fire;

    int checks = 0;
    int errors = 0;

    neuron_alu2_sequencer_if #(.nBits(NB)) bus ();

    neuron_alu2_sequencer #(.nBits(NB), .NIN(NIN)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .threshold (threshold),
`ifdef NEURON_SEQ_BIAS_EN
        .bias      (bias),
`endif
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .out_acc   (out_acc),
        .out_fire  (out_fire)
    );

    always #5 clk = ~clk;

    // Reference ALU2: combinational, same-cycle result.
    always_comb begin
        case (bus.alu_ctrl)
            3'b000:  bus.alu_result = bus.alu_a + bus.alu_c;
            3'b001:  bus.alu_result = bus.alu_a * bus.alu_c;
            3'b010:  bus.alu_result = ($signed(bus.alu_a) >= $signed(bus.alu_c)) ? 32'sd1 : 32'sd0;
            default: bus.alu_result = bus.alu_a;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "/busy"},     32'(busy),         32'd0);
        chk({tag, "/done"},     32'(done),         32'd0);
        chk({tag, "/in_ready"}, 32'(bus.in_ready), 32'd0);
        chk({tag, "/out_acc"},  out_acc,           32'd0);
        chk({tag, "/out_fire"}, 32'(out_fire),     32'd0);
        chk({tag, "/alu_ctrl"}, 32'(bus.alu_ctrl), 32'd7);
        chk({tag, "/alu_a"},    bus.alu_a,         32'd0);
        chk({tag, "/alu_c"},    bus.alu_c,         32'd0);
    endtask

    // Runs one neuron from IDLE; optional stall before pair stall_idx and a start pulse at mid_cyc.
    task automatic run_neuron(input string tag, input vec_t xs, input vec_t ws,
                              input logic signed [NB-1:0] thr, input int stall_idx,
                              input int stall_n, input int mid_cyc,
                              input logic signed [NB-1:0] exp_sum, input int exp_lat);
        int                   cyc;
        int                   idx;
        int                   stall_left;
        int                   mst;
        logic signed [NB-1:0] part;
        logic signed [NB-1:0] exp_acc;
        logic                 exp_fire;
        exp_acc  = exp_sum + BIAS;
        exp_fire = (exp_acc >= thr);
        chk({tag, "/idle_ctrl"}, 32'(bus.alu_ctrl), 32'd7);
        threshold    = thr;
        bus.in_valid = 1'b0;
        start        = 1'b1;
        @(posedge clk); #1;
        start      = 1'b0;
        threshold  = '0;
        mst        = M_MUL;
        cyc        = 1;
        idx        = 0;
        stall_left = stall_n;
        part       = BIAS;
        while (mst != M_DONE && cyc < 64) begin
            start        = (cyc == mid_cyc);
            bus.in_valid = 1'b0;
            bus.in_x     = '0;
            bus.in_w     = '0;
            case (mst)
                M_MUL: begin
                    chk({tag, "/mul_ctrl"}, 32'(bus.alu_ctrl), 32'd1);
                    if (idx == stall_idx && stall_left > 0) begin
                        chk({tag, "/stall_ready"}, 32'(bus.in_ready), 32'd1);
                        stall_left--;
                    end else begin
                        bus.in_valid = 1'b1;
                        bus.in_x     = xs[idx];
                        bus.in_w     = ws[idx];
                    end
                end
                M_ACC: begin
                    chk({tag, "/acc_ctrl"}, 32'(bus.alu_ctrl), 32'd0);
                    chk({tag, "/acc_val"},  bus.alu_a,         part);
                end
                default: begin
                    chk({tag, "/thr_ctrl"}, 32'(bus.alu_ctrl), 32'd2);
                    chk({tag, "/thr_done"}, 32'(done),         32'd0);
                end
            endcase
            @(posedge clk); #1;
            cyc++;
            case (mst)
                M_MUL: if (bus.in_valid) mst = M_ACC;
                M_ACC: begin
                    part = part + xs[idx] * ws[idx];
                    idx++;
                    mst = (idx == NIN) ? M_THR : M_MUL;
                end
                default: mst = M_DONE;
            endcase
        end
        start        = 1'b0;
        bus.in_valid = 1'b0;
        chk({tag, "/done"},     32'(done),         32'd1);
        chk({tag, "/latency"},  32'(cyc),          32'(exp_lat));
        chk({tag, "/out_acc"},  out_acc,           exp_acc);
        chk({tag, "/out_fire"}, 32'(out_fire),     32'(exp_fire));
        chk({tag, "/busy_dn"},  32'(busy),         32'd1);
        chk({tag, "/done_ctrl"},32'(bus.alu_ctrl), 32'd7);
        @(posedge clk); #1;
        chk({tag, "/done_pulse"}, 32'(done),    32'd0);
        chk({tag, "/idle_busy"},  32'(busy),    32'd0);
        chk({tag, "/hold_acc"},   out_acc,      exp_acc);
        chk({tag, "/hold_fire"},  32'(out_fire),32'(exp_fire));
    endtask

    initial begin
        vec_t x_ramp, w_ones, x_neg, w_neg, x_ovf, w_ovf;
        x_ramp = '{32'sd1, 32'sd2, 32'sd3, 32'sd4};
        w_ones = '{32'sd1, 32'sd1, 32'sd1, 32'sd1};
        x_neg  = '{-32'sd3, 32'sd0, 32'sd0, 32'sd0};
        w_neg  = '{32'sd2, 32'sd0, 32'sd0, 32'sd0};
        x_ovf  = '{32'sh7FFF_FFFF, 32'sd0, 32'sd0, 32'sd0};
        w_ovf  = '{32'sd2, 32'sd0, 32'sd0, 32'sd0};
        bus.in_valid = 1'b0;
        bus.in_x     = '0;
        bus.in_w     = '0;

        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("por");
        reset_n = 1'b1;
        @(posedge clk); #1;

        run_neuron("s1_fire",   x_ramp, w_ones, 32'sd10, -1, 0, -1, 32'sd10, 10);
        run_neuron("s2_nofire", x_ramp, w_ones, 32'sd11, -1, 0, -1, 32'sd10, 10);
        run_neuron("s2_neg",    x_neg,  w_neg,  -32'sd6, -1, 0, -1, -32'sd6, 10);
        run_neuron("s3_stall",  x_ramp, w_ones, 32'sd10,  1, 3, -1, 32'sd10, 13);
        run_neuron("s4_ovf",    x_ovf,  w_ovf,  32'sd0,  -1, 0, -1, 32'shFFFF_FFFE, 10);
        run_neuron("s5_midst",  x_ramp, w_ones, 32'sd10, -1, 0,  3, 32'sd10, 10);
        repeat (3) begin
            @(posedge clk); #1;
            chk("s5_no_restart", 32'(busy), 32'd0);
        end

        // Abort in ACC: outputs must drop to reset values without waiting for a clock.
        threshold = 32'sd10;
        start     = 1'b1;
        @(posedge clk); #1;
        start        = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_x     = 32'sd1;
        bus.in_w     = 32'sd1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("rst/in_acc", 32'(bus.alu_ctrl), 32'd0);
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("rst_mid");
        repeat (3) begin
            @(posedge clk); #1;
            chk("rst/no_done", 32'(done), 32'd0);
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
        run_neuron("s5_after_rst", x_ramp, w_ones, 32'sd10, -1, 0, -1, 32'sd10, 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
